matrix_mult_matrix_seq: RTL
===========================

// Module: matrix_mult_matrix_seq
// PURPOSE
//  Parametrised, time-multiplexed successor to the combinational 3x3 matrix product.
//  Computes C = A x B for unsigned NxN matrices. Uses one N-wide dot-product datapath
//  and produces one C element per cycle. Valid/ready handshakes on input and output
//  let it sit between streaming stages; backpressure holds the result.
// PARAMETERS
//  N     3   matrix dimension (N >= 2)
//  DW    3   element width of A and B, unsigned
//  OW    8   element width of C; full precision needs 2*DW+$clog2(N), narrower truncates mod 2^OW
// PORTS
//  clk        in   1         clock; all state updates on the rising edge
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         A/B operands valid
//  in_ready   out  1         block accepts operands this cycle
//  mat_a      in   N*N*DW    A, row-major: A(r,c) = mat_a[DW*(r*N+c) +: DW]
//  mat_b      in   N*N*DW    B, row-major: B(r,c) = mat_b[DW*(r*N+c) +: DW]
//  out_valid  out  1         result valid
//  out_ready  in   1         downstream accepts result
//  mat_c      out  N*N*OW    C, row-major: C(r,c) = mat_c[OW*(r*N+c) +: OW]
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, mat_c=0, idx=0, A/B registers=0.
//   rst has priority over every other event, including mid-COMPUTE and while DONE
//   is waiting on out_ready; the in-flight result is discarded.
//  FSM IDLE -> COMPUTE -> DONE -> IDLE:
//   IDLE: in_ready=1. On in_valid&in_ready, latch mat_a/mat_b, idx<=0, go COMPUTE.
//   COMPUTE: in_ready=0. Each cycle:
//     r=idx/N, c=idx%N
//     C(r,c) <= sum_k A(r,k)*B(k,c), mod 2^OW
//     idx<=idx+1
//    On idx==N*N-1, write the last element and go DONE.
//   DONE: out_valid=1, in_ready=0. mat_c and out_valid hold stable until out_ready=1.
//    On out_valid&out_ready, out_valid<=0 and go IDLE next cycle.
//  Latency: handshake at edge T; elements written at edges T+1..T+N*N.
//   out_valid is high in the cycle after edge T+N*N.
//   Minimum initiation interval is N*N+2 cycles.
//  in_valid outside IDLE is ignored; operands are not sampled. mat_a/mat_b may change
//   freely after acceptance because A/B are registered.
//  mat_c elements not yet written in COMPUTE keep their previous values.
//   Only the DONE-state value is architecturally defined.
//  Arithmetic: products are 2*DW bits, the sum is computed at full width, and the
//   assignment truncates to OW LSBs. No saturation.
//  out_ready asserted outside DONE has no effect.
//  idx is $clog2(N*N) bits wide and never wraps past N*N-1.
// TESTING
//  1 N=3, A=identity, B=[1..9] row-major -> C=[1..9]; out_valid 10 cycles after accept.
//  2 N=3, all A,B elements 7 -> every C element 147 (8'h93); no truncation at OW=8.
//  3 OW=6, same all-7 input -> every C element 147 mod 64 = 19.
//  4 Backpressure: hold out_ready=0 for 20 cycles in DONE -> mat_c/out_valid stable,
//    in_ready=0, in_valid pulses ignored; release -> one transfer, then IDLE.
//  5 rst=1 at COMPUTE cycle 4 -> next cycle IDLE, out_valid=0, mat_c=0; new A=B=identity
//    -> C=identity.
//  6 Back-to-back: in_valid held high with 3 distinct A/B sets, random out_ready ->
//    3 results in order, matching the reference model; accepts spaced >= N*N+2 cycles.

Source files
------------

// File: rtl/matrix_mult_matrix_seq.sv
// -----------------------------------------------------------------------------
// matrix_mult_matrix_seq
//
// Time-multiplexed unsigned matrix product C = A x B for NxN matrices.
// One N-wide dot-product datapath computes one element of C per cycle.
// Operands are registered when accepted. The finished matrix is held on mat_c
// with out_valid until the downstream stage takes it.
//
// Parameters
//   N   matrix dimension (N >= 2)
//   DW  element width of A and B (unsigned)
//   OW  element width of C; results are truncated mod 2^OW
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   A/B operands valid
//   in_ready   block accepts operands this cycle (IDLE only)
//   mat_a      A, row-major: A(r,c) = mat_a[DW*(r*N+c) +: DW]
//   mat_b      B, row-major: B(r,c) = mat_b[DW*(r*N+c) +: DW]
//   out_valid  result valid; held with mat_c until out_ready
//   out_ready  downstream accepts result
//   mat_c      C, row-major: C(r,c) = mat_c[OW*(r*N+c) +: OW]
// -----------------------------------------------------------------------------
module matrix_mult_matrix_seq #(
    parameter int N  = 3,
    parameter int DW = 3,
    parameter int OW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*N*DW-1:0]   mat_a,
    input  logic [N*N*DW-1:0]   mat_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*N*OW-1:0]   mat_c
);

    localparam int NN = N * N;
    localparam int IW = $clog2(NN);
    // Width that holds a full-precision sum of N products of two DW-bit values.
    localparam int SW = 2 * DW + $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    state_t              state;
    logic [IW-1:0]       idx;
    logic [NN*DW-1:0]    a_q;
    logic [NN*DW-1:0]    b_q;
    logic [SW-1:0]       dot;
    logic [31:0]         row;
    logic [31:0]         col;

    // Dot product of row `row` of A with column `col` of B for the element
    // currently addressed by idx.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        dot = '0;
        row = 32'(idx) / 32'(N);
        col = 32'(idx) % 32'(N);
        for (int k = 0; k < N; k++) begin
            dot = dot + SW'(a_q[DW*(row*N+k) +: DW]) * SW'(b_q[DW*(k*N+col) +: DW]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mat_c     <= '0;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= mat_a;
                        b_q      <= mat_b;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= COMPUTE;
                    end
                end

                COMPUTE: begin
                    mat_c[OW*idx +: OW] <= OW'(dot);
                    if (idx == IW'(NN - 1)) begin
                        // idx stays at the last element; it is reloaded on the next accept.
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
